// File: rtl/crossroad_scheduler_if.sv
// Bundles the arrival/force strobes and the display-facing status, light and counter
// outputs of the crossroad scheduler into one connection.
interface crossroad_scheduler_if #(
  parameter int unsigned CNT_W = 4
);
  logic             car_arrived_a1;
  logic             car_arrived_a2;
  logic             car_arrived_b1;
  logic             car_arrived_b2;
  logic             force_switch;
  logic [1:0]       crossroad_status;
  logic [1:0]       light_a;
  logic [1:0]       light_b;
  logic [CNT_W-1:0] car_counter_a1;
  logic [CNT_W-1:0] car_counter_a2;
  logic [CNT_W-1:0] car_counter_b1;
  logic [CNT_W-1:0] car_counter_b2;
  logic             car_passed_a;
  logic             car_passed_b;
  logic             tick;

  modport master (
    output car_arrived_a1, car_arrived_a2, car_arrived_b1, car_arrived_b2, force_switch,
    input  crossroad_status, light_a, light_b,
    input  car_counter_a1, car_counter_a2, car_counter_b1, car_counter_b2,
    input  car_passed_a, car_passed_b, tick
  );

  modport slave (
    input  car_arrived_a1, car_arrived_a2, car_arrived_b1, car_arrived_b2, force_switch,
    output crossroad_status, light_a, light_b,
    output car_counter_a1, car_counter_a2, car_counter_b1, car_counter_b2,
    output car_passed_a, car_passed_b, tick
  );
endinterface

// File: rtl/crossroad_scheduler.sv
// Two-direction crossroad sequencer: phase FSM with green/yellow/all-red timing,
// four saturating lane queues, tick-paced departures and a sticky force-handover request.
module crossroad_scheduler #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned MIN_GREEN    = 4,
  parameter int unsigned MAX_GREEN    = 10,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned PASS_TICKS   = 1,
  parameter int unsigned CNT_W        = 4
) (
  input logic                 CLK100MHZ,
  input logic                 CPU_RESETN,
  crossroad_scheduler_if.slave bus
);

  localparam int unsigned PS_W = $clog2(TICK_DIV);
  localparam int unsigned PH_W = $clog2(MAX_GREEN + 1);
  localparam int unsigned PA_W = (PASS_TICKS > 1) ? $clog2(PASS_TICKS) : 1;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0]  PS_PRE  = PS_W'(TICK_DIV - 2);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(MAX_GREEN);
  localparam logic [PA_W-1:0]  PA_LAST = PA_W'(PASS_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick_q, tick_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [PA_W-1:0]  pass_q, pass_d;
  logic             force_q, force_d;
  logic             pa_q, pa_d;
  logic             pb_q, pb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic [31:0] n_s;
  logic [3:0]  arr_s;
  logic [3:0]  nz_s;
  logic [3:0]  dec_s;
  logic        a_busy_s, b_busy_s;
  logic        green_s, dep_s, enter_green_s;

  assign arr_s    = {bus.car_arrived_b2, bus.car_arrived_b1, bus.car_arrived_a2, bus.car_arrived_a1};
  assign nz_s     = {|cnt_q[3], |cnt_q[2], |cnt_q[1], |cnt_q[0]};
  assign a_busy_s = nz_s[0] | nz_s[1];
  assign b_busy_s = nz_s[2] | nz_s[3];
  assign green_s  = (state_q == A_GREEN) || (state_q == B_GREEN);
  assign n_s      = 32'(ph_q) + 32'd1;

  // tick_q is registered one count early so it is high exactly while ps_q == TICK_DIV-1
  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    tick_d = (ps_q == PS_PRE);
  end

  always_comb begin
    state_d = state_q;
    dep_s   = 1'b0;
    if (tick_q) begin
      case (state_q)
        A_GREEN: begin
          if (b_busy_s && (n_s >= MAX_GREEN || (n_s >= MIN_GREEN && (!a_busy_s || force_q)))) begin
            state_d = A_YELLOW;
          end else begin
            state_d = A_GREEN;
          end
        end
        A_YELLOW:  state_d = (n_s == YELLOW_TICKS) ? ALLRED_AB : A_YELLOW;
        ALLRED_AB: state_d = (n_s == ALLRED_TICKS) ? B_GREEN : ALLRED_AB;
        B_GREEN: begin
          if (a_busy_s && (n_s >= MAX_GREEN || (n_s >= MIN_GREEN && (!b_busy_s || force_q)))) begin
            state_d = B_YELLOW;
          end else begin
            state_d = B_GREEN;
          end
        end
        B_YELLOW:  state_d = (n_s == YELLOW_TICKS) ? ALLRED_BA : B_YELLOW;
        ALLRED_BA: state_d = (n_s == ALLRED_TICKS) ? A_GREEN : ALLRED_BA;
        default:   state_d = A_GREEN;
      endcase
      dep_s = green_s && (pass_q == PA_LAST);
    end else begin
      state_d = state_q;
      dep_s   = 1'b0;
    end

    enter_green_s = (state_d != state_q) && (state_d == A_GREEN || state_d == B_GREEN);
    ph_d    = (state_d != state_q) ? '0
            : (tick_q && ph_q < PH_MAX) ? ph_q + PH_W'(1) : ph_q;
    pass_d  = enter_green_s ? '0
            : (tick_q && green_s) ? (dep_s ? '0 : pass_q + PA_W'(1)) : pass_q;
    force_d = enter_green_s ? 1'b0 : (force_q | bus.force_switch);
    pa_d    = dep_s && (state_q == A_GREEN) && a_busy_s;
    pb_d    = dep_s && (state_q == B_GREEN) && b_busy_s;
    dec_s   = {{2{dep_s && (state_q == B_GREEN)}}, {2{dep_s && (state_q == A_GREEN)}}} & nz_s;
  end

  // An arrival and a departure on the same lane cancel, so a full lane stays full
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      case ({arr_s[i], dec_s[i]})
        2'b10:   cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= A_GREEN;
      ps_q    <= '0;
      tick_q  <= 1'b0;
      ph_q    <= '0;
      pass_q  <= '0;
      force_q <= 1'b0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      tick_q  <= tick_d;
      ph_q    <= ph_d;
      pass_q  <= pass_d;
      force_q <= force_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.crossroad_status = 2'd2;
    bus.light_a          = 2'd0;
    bus.light_b          = 2'd0;
    case (state_q)
      A_GREEN: begin
        bus.crossroad_status = 2'd0;
        bus.light_a          = 2'd2;
      end
      A_YELLOW: bus.light_a = 2'd1;
      B_GREEN: begin
        bus.crossroad_status = 2'd1;
        bus.light_b          = 2'd2;
      end
      B_YELLOW: bus.light_b = 2'd1;
      default: begin
        bus.crossroad_status = 2'd2;
        bus.light_a          = 2'd0;
        bus.light_b          = 2'd0;
      end
    endcase
  end

  assign bus.car_counter_a1 = cnt_q[0];
  assign bus.car_counter_a2 = cnt_q[1];
  assign bus.car_counter_b1 = cnt_q[2];
  assign bus.car_counter_b2 = cnt_q[3];
  assign bus.car_passed_a   = pa_q;
  assign bus.car_passed_b   = pb_q;
  assign bus.tick           = tick_q;

endmodule

// File: tb/tb_crossroad_scheduler.sv
// Checks crossroad_scheduler against a phase/queue model kept in plain integers,
// with directed scenarios pinned by hand-computed cycle expectations plus random traffic.
module tb_crossroad_scheduler;

  localparam int TD   = 4;
  localparam int MING = 3;
  localparam int MAXG = 6;
  localparam int YT   = 2;
  localparam int ART  = 1;
  localparam int PT   = 2;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  // phase: 0 A green, 1 A yellow, 2 all-red A->B, 3 B green, 4 B yellow, 5 all-red B->A
  int m_phase;
  int m_pticks;
  int m_gticks;
  int m_cnt [4];
  bit m_force;
  bit m_pa;
  bit m_pb;

  crossroad_scheduler_if #(.CNT_W(CW)) bus ();

  crossroad_scheduler #(
    .TICK_DIV(TD), .MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_TICKS(YT),
    .ALLRED_TICKS(ART), .PASS_TICKS(PT), .CNT_W(CW)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_pticks = 0;
    m_gticks = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_force = 1'b0;
    m_pa    = 1'b0;
    m_pb    = 1'b0;
    cyc     = 0;
  endtask

  task automatic compare_all();
    int st, la, lb;
    st = (m_phase == 0) ? 0 : (m_phase == 3) ? 1 : 2;
    la = (m_phase == 0) ? 2 : (m_phase == 1) ? 1 : 0;
    lb = (m_phase == 3) ? 2 : (m_phase == 4) ? 1 : 0;
    check("status", int'(bus.crossroad_status), st);
    check("light_a", int'(bus.light_a), la);
    check("light_b", int'(bus.light_b), lb);
    check("cnt_a1", int'(bus.car_counter_a1), m_cnt[0]);
    check("cnt_a2", int'(bus.car_counter_a2), m_cnt[1]);
    check("cnt_b1", int'(bus.car_counter_b1), m_cnt[2]);
    check("cnt_b2", int'(bus.car_counter_b2), m_cnt[3]);
    check("passed_a", int'(bus.car_passed_a), int'(m_pa));
    check("passed_b", int'(bus.car_passed_b), int'(m_pb));
    check("tick", int'(bus.tick), ((cyc % TD) == TD - 1) ? 1 : 0);
  endtask

  task automatic model_step(input logic [3:0] arr, input logic f);
    bit tk, green, waiting, own_empty;
    int nxt, n, own0, oth0, limit;
    int dec [4];
    tk    = ((cyc % TD) == TD - 1);
    green = (m_phase == 0) || (m_phase == 3);
    nxt   = m_phase;
    for (int i = 0; i < 4; i++) dec[i] = 0;
    m_pa = 1'b0;
    m_pb = 1'b0;
    if (tk) begin
      n = m_pticks + 1;
      if (green) begin
        own0 = (m_phase == 0) ? 0 : 2;
        oth0 = (m_phase == 0) ? 2 : 0;
        waiting   = (m_cnt[oth0] + m_cnt[oth0 + 1]) > 0;
        own_empty = (m_cnt[own0] + m_cnt[own0 + 1]) == 0;
        if ((m_gticks + 1) % PT == 0) begin
          for (int i = own0; i < own0 + 2; i++) if (m_cnt[i] > 0) dec[i] = 1;
          if (m_phase == 0) m_pa = !own_empty;
          else              m_pb = !own_empty;
        end
        if (waiting && (n >= MAXG || (n >= MING && (own_empty || m_force)))) nxt = m_phase + 1;
      end else begin
        limit = (m_phase == 1 || m_phase == 4) ? YT : ART;
        if (n == limit) nxt = (m_phase + 1) % 6;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = m_cnt[i] + (arr[i] ? 1 : 0) - dec[i];
      if (m_cnt[i] > CMAX) m_cnt[i] = CMAX;
    end
    if (nxt != m_phase && (nxt == 0 || nxt == 3)) m_force = 1'b0;
    else                                          m_force = m_force | f;
    if (nxt != m_phase) begin
      m_pticks = 0;
      m_gticks = 0;
    end else if (tk) begin
      m_pticks++;
      if (green) m_gticks++;
    end
    m_phase = nxt;
  endtask

  task automatic set_inputs(input logic [3:0] arr, input logic f);
    bus.car_arrived_a1 = arr[0];
    bus.car_arrived_a2 = arr[1];
    bus.car_arrived_b1 = arr[2];
    bus.car_arrived_b2 = arr[3];
    bus.force_switch   = f;
  endtask

  task automatic run_cycle(input logic [3:0] arr, input logic f);
    set_inputs(arr, f);
    @(negedge clk);
    compare_all();
    model_step(arr, f);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_inputs(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_status"}, int'(bus.crossroad_status), 0);
    check({tag, "_light_a"}, int'(bus.light_a), 2);
    check({tag, "_light_b"}, int'(bus.light_b), 0);
    check({tag, "_cnt_sum"}, int'(bus.car_counter_a1) + int'(bus.car_counter_a2)
                             + int'(bus.car_counter_b1) + int'(bus.car_counter_b2), 0);
    check({tag, "_pulses"}, int'(bus.car_passed_a) + int'(bus.car_passed_b), 0);
    check({tag, "_tick"}, int'(bus.tick), 0);
  endtask

  initial begin
    logic [3:0] arr;
    logic       f;
    clk    = 1'b0;
    rst_n  = 1'b0;
    checks = 0;
    errors = 0;
    set_inputs(4'b0000, 1'b0);

    // Idle: A keeps the green, tick every TD cycles starting at cycle 3
    do_reset();
    check_reset_values("rst");
    for (int i = 0; i < 200; i++) begin
      run_cycle(4'b0000, 1'b0);
      if (cyc == 3 || cyc == 7 || cyc == 199) check("idle_tick_hi", int'(bus.tick), 1);
      if (cyc == 5 || cyc == 198) check("idle_tick_lo", int'(bus.tick), 0);
    end
    check("idle_light_a", int'(bus.light_a), 2);

    // Two cars on b1: handover on A tick 3, B drains on its ticks 2 and 4
    do_reset();
    for (int i = 0; i < 120; i++) begin
      arr = (cyc == 5 || cyc == 6) ? 4'b0100 : 4'b0000;
      run_cycle(arr, 1'b0);
      if (cyc == 11) check("b_scn_still_green", int'(bus.light_a), 2);
      if (cyc == 12) check("b_scn_yellow", int'(bus.light_a), 1);
      if (cyc == 20) check("b_scn_allred", int'(bus.crossroad_status), 2);
      if (cyc == 24) check("b_scn_b_green", int'(bus.crossroad_status), 1);
      if (cyc == 32) check("b_scn_b1_one", int'(bus.car_counter_b1), 1);
      if (cyc == 32) check("b_scn_pass_b", int'(bus.car_passed_b), 1);
      if (cyc == 40) check("b_scn_b1_zero", int'(bus.car_counter_b1), 0);
      if (cyc == 119) check("b_scn_b_holds", int'(bus.crossroad_status), 1);
    end

    // a1=5, b1=1: A only leaves at MAX_GREEN, with a1 at 2
    do_reset();
    for (int i = 0; i < 40; i++) begin
      arr = {1'b0, (cyc == 0), 1'b0, (cyc <= 4)};
      run_cycle(arr, 1'b0);
      if (cyc == 23) check("max_still_green", int'(bus.light_a), 2);
      if (cyc == 24) check("max_yellow", int'(bus.light_a), 1);
      if (cyc == 24) check("max_a1_at_exit", int'(bus.car_counter_a1), 2);
      if (cyc == 24) check("max_pass_a", int'(bus.car_passed_a), 1);
    end

    // Nine a1 arrivals: saturates at 7, arrival+departure on cycle 7 keeps it at 7
    do_reset();
    for (int i = 0; i < 12; i++) begin
      arr = {3'b000, (cyc <= 8)};
      run_cycle(arr, 1'b0);
      if (cyc == 6) check("sat_a1_six", int'(bus.car_counter_a1), 6);
      if (cyc == 8) check("sat_a1_same", int'(bus.car_counter_a1), 7);
      if (cyc == 8) check("sat_pass_a", int'(bus.car_passed_a), 1);
      if (cyc == 10) check("sat_a1_held", int'(bus.car_counter_a1), 7);
    end

    // Force at A tick 1 exits on tick 3; force during yellow is dropped at B entry
    do_reset();
    for (int i = 0; i < 49; i++) begin
      arr = {1'b0, (cyc <= 2), 1'b0, (cyc <= 2)};
      f   = (cyc == 3 || cyc == 13);
      run_cycle(arr, f);
      if (cyc == 11) check("frc_still_green", int'(bus.light_a), 2);
      if (cyc == 12) check("frc_yellow", int'(bus.light_a), 1);
      if (cyc == 24) check("frc_b_green", int'(bus.crossroad_status), 1);
      if (cyc == 36) check("frc_dropped", int'(bus.light_b), 2);
      if (cyc == 47) check("frc_b_max_hold", int'(bus.light_b), 2);
      if (cyc == 48) check("frc_b_yellow", int'(bus.light_b), 1);
    end

    // Asynchronous reset in the middle of B yellow
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_cycle(4'b0000, 1'b0);
      if (cyc == 2) check("post_rst_no_tick", int'(bus.tick), 0);
      if (cyc == 3) check("post_rst_first_tick", int'(bus.tick), 1);
    end

    // Random traffic, dense then sparse
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) arr[k] = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 15) == 0);
      run_cycle(arr, f);
    end
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) arr[k] = ($urandom_range(0, 11) == 0);
      f = ($urandom_range(0, 39) == 0);
      run_cycle(arr, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
